// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch PC path: fetch FSM encoding
// and the default reset PC / bubble instruction.
package pc_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ack channel plus the
// IF/ID hand-off (inst_valid/inst/inst_pc with decode back-pressure).
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Fetch unit side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  stall,
        output inst_valid,
        output inst,
        output inst_pc
    );

    // Memory / decode side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output stall,
        input  inst_valid,
        input  inst,
        input  inst_pc
    );

endinterface

// File: rtl/pc_fetch_unit_pc_reg.sv
// Architectural PC register with +4 incrementer and a load mux.
// pc_nxt exposes the value the PC takes at the next edge so the
// fetch address register can follow it without a cycle of lag.
module pc_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [31:0] load_val,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] pc_nxt
);

    // Wraps modulo 2^32, so 0xFFFF_FFFC increments to 0.
    assign pc4    = pc + PC_STEP;
    assign pc_nxt = load_en ? load_val : pc;

    // PC flop, loaded only when the fetch FSM asks for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch end of the PC path. Holds the PC, issues one req/ack
// fetch at a time and presents the fetched word to the IF/ID stage.
// A redirect that arrives while a request is outstanding cannot cancel the
// memory transaction, so kill_q marks its response for discard.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] INST_NOP = DEF_INST_NOP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        next_pc,
    input  logic               redirect,
    output logic [31:0]        pc4,
    pc_fetch_unit_if.master    bus
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic         valid_q, valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  addr_q;
    logic         addr_hold;
    logic         pc_ld;
    logic [31:0]  pc_ld_val;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (pc_ld),
        .load_val (pc_ld_val),
        .pc       (pc),
        .pc4      (pc4),
        .pc_nxt   (pc_nxt)
    );

    // Fetch FSM next-state, PC load control and IF/ID register updates
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_ld     = 1'b0;
        pc_ld_val = next_pc;
        addr_hold = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Any ack seen here belongs to a pre-reset request and is ignored.
                state_d = ST_REQ;
                pc_ld   = redirect;
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (kill_q || redirect) begin
                        // Stale response: drop it and re-issue from the (new) PC.
                        kill_d = 1'b0;
                        pc_ld  = redirect;
                    end else begin
                        inst_d    = bus.imem_rdata;
                        inst_pc_d = pc;
                        valid_d   = 1'b1;
                        pc_ld     = 1'b1;
                        pc_ld_val = pc4;
                        state_d   = ST_HOLD;
                    end
                end else begin
                    // Address must stay put until memory answers.
                    addr_hold = 1'b1;
                    if (redirect) begin
                        pc_ld  = 1'b1;
                        kill_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    inst_d  = INST_NOP;
                    pc_ld   = 1'b1;
                    state_d = ST_REQ;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                    inst_d  = INST_NOP;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and pending-discard flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // Fetch address tracks the upcoming PC except while a request waits for ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= RESET_PC;
        end else if (!addr_hold) begin
            addr_q <= pc_nxt;
        end
    end

    // IF/ID output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            inst_q    <= INST_NOP;
            inst_pc_q <= 32'h0000_0000;
        end else begin
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign bus.imem_req   = (state_q == ST_REQ);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

endmodule
